// File: rtl/cpu_defs_pkg.sv
// -----------------------------------------------------------------------------
// cpu_defs_pkg
// Shared definitions for the iterative divider: FSM state encoding, the
// default iteration count and a small two's-complement helper.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_defs_pkg;

    // One radix-2 step per cycle, one quotient bit per step.
    localparam int unsigned DIV_ITERS_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        ZERO = 2'b10,
        DONE = 2'b11
    } div_state_e;

    // Conditional two's-complement negation.
    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_core.sv
// -----------------------------------------------------------------------------
// div_core
// Restoring shift/subtract datapath for unsigned 32-bit division. Holds the
// partial remainder, the quotient register (which initially carries the
// dividend and shifts it out MSB-first) and the iteration counter.
//
// Ports
//   clk, resetn     clock, synchronous active-low reset
//   clear_i         zero all registers (in-flight division killed)
//   load_i          start: remainder=0, quotient=dividend_i, divisor=divisor_i
//   dividend_i      dividend magnitude
//   divisor_i       divisor magnitude
//   step_i          perform one shift-subtract step
//   zload_i         divide-by-zero: remainder=zhi_i, quotient=all ones
//   zhi_i           value loaded into the remainder on zload_i
//   rem_o, quo_o    current remainder / quotient registers
//   last_o          the step taken this cycle is the final one
// -----------------------------------------------------------------------------
module div_core
    import cpu_defs_pkg::*;
#(
    parameter int unsigned DIV_ITERS = DIV_ITERS_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        step_i,
    input  logic        zload_i,
    input  logic [31:0] zhi_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o,
    output logic        last_o
);

    localparam int unsigned CNT_W = $clog2(DIV_ITERS + 1);

    logic [31:0]      rem_q, rem_d;
    logic [31:0]      quo_q, quo_d;
    logic [31:0]      dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Shifted partial remainder needs 33 bits: rem < divisor < 2^32, so
    // 2*rem + 1 can exceed 32 bits.
    logic [32:0] rem_sh;
    logic        fits;

    always_comb begin
        rem_sh = {rem_q, quo_q[31]};
        fits   = (rem_sh >= {1'b0, dvs_q});

        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;

        if (clear_i) begin
            rem_d = '0;
            quo_d = '0;
            dvs_d = '0;
            cnt_d = '0;
        end else if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
            cnt_d = '0;
        end else if (zload_i) begin
            rem_d = zhi_i;
            quo_d = '1;
        end else if (step_i) begin
            rem_d = fits ? 32'(rem_sh - {1'b0, dvs_q}) : rem_sh[31:0];
            quo_d = {quo_q[30:0], fits};
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign rem_o  = rem_q;
    assign quo_o  = quo_q;
    assign last_o = (cnt_q == CNT_W'(DIV_ITERS - 1));

endmodule

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Multi-cycle DIV/DIVU unit for the execute stage. Owns the FSM, operand sign
// handling and the stall/ready handshake; the iterative datapath is div_core.
//
// Ports
//   clk        rising-edge clock
//   resetn     synchronous active-low reset
//   start_i    DIV/DIVU present with valid operands
//   signed_i   1 = DIV, 0 = DIVU (sampled with start_i)
//   opa_i      dividend (sampled with start_i)
//   opb_i      divisor  (sampled with start_i)
//   annul_i    exception flush, kills any in-flight division
//   stall_o    pipeline stall request
//   ready_o    one-cycle pulse, result_o valid this cycle
//   result_o   {hi = remainder, lo = quotient}; holds last result otherwise
//
// Optional build macro DIV_EARLY_OUT_EN: when |dividend| < |divisor| the
// division completes in one cycle (IDLE -> DONE) with lo=0, hi=dividend.
// -----------------------------------------------------------------------------
module div_ctrl
    import cpu_defs_pkg::*;
#(
    parameter int unsigned DIV_ITERS = DIV_ITERS_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic        annul_i,
    output logic        stall_o,
    output logic        ready_o,
    output logic [63:0] result_o
);

    div_state_e state_q, state_d;

    logic        signed_q;
    logic        sa_q, sb_q;      // raw operand sign bits
    logic        div0_q;          // divisor was zero
    logic        early_q;         // early-out path taken
    logic [63:0] result_q, result_d;
    logic        capture;

    logic        core_clear, core_load, core_step, core_zload, core_last;
    logic [31:0] core_rem, core_quo, core_zhi;

    logic        neg_a_in, neg_b_in;
    logic [31:0] mag_a, mag_b;
    logic        early_hit;

    logic [31:0] raw_a, quo_c, rem_c;
    logic [63:0] done_res;

    assign neg_a_in = signed_i & opa_i[31];
    assign neg_b_in = signed_i & opb_i[31];
    assign mag_a    = neg_if(neg_a_in, opa_i);
    assign mag_b    = neg_if(neg_b_in, opb_i);

`ifdef DIV_EARLY_OUT_EN
    assign early_hit = (opb_i != '0) && (mag_a < mag_b);
`else
    assign early_hit = 1'b0;
`endif

    // Until BUSY starts stepping, the core's quotient register still holds the
    // dividend magnitude, so the signed dividend can be rebuilt from it for the
    // divide-by-zero and early-out results.
    assign raw_a    = neg_if(signed_q & sa_q, core_quo);
    assign core_zhi = raw_a;
    assign quo_c    = neg_if(signed_q & (sa_q ^ sb_q), core_quo);
    assign rem_c    = neg_if(signed_q & sa_q, core_rem);

    always_comb begin
        if (div0_q) begin
            done_res = {core_rem, core_quo};
        end else if (early_q) begin
            done_res = {raw_a, 32'h0};
        end else begin
            done_res = {rem_c, quo_c};
        end
    end

    div_core #(
        .DIV_ITERS (DIV_ITERS)
    ) u_core (
        .clk        (clk),
        .resetn     (resetn),
        .clear_i    (core_clear),
        .load_i     (core_load),
        .dividend_i (mag_a),
        .divisor_i  (mag_b),
        .step_i     (core_step),
        .zload_i    (core_zload),
        .zhi_i      (core_zhi),
        .rem_o      (core_rem),
        .quo_o      (core_quo),
        .last_o     (core_last)
    );

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        result_o   = result_q;
        stall_o    = 1'b0;
        ready_o    = 1'b0;
        capture    = 1'b0;
        core_clear = 1'b0;
        core_load  = 1'b0;
        core_step  = 1'b0;
        core_zload = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    stall_o   = 1'b1;
                    capture   = 1'b1;
                    core_load = 1'b1;
                    if (opb_i == '0) begin
                        state_d = ZERO;
                    end else if (early_hit) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_o   = 1'b1;
                core_step = 1'b1;
                if (core_last) begin
                    state_d = DONE;
                end
            end
            ZERO: begin
                stall_o    = 1'b1;
                core_zload = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                ready_o  = 1'b1;
                result_o = done_res;
                result_d = done_res;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides everything, including a pending DONE.
        if (annul_i) begin
            state_d    = IDLE;
            result_d   = result_q;
            result_o   = result_q;
            stall_o    = 1'b0;
            ready_o    = 1'b0;
            capture    = 1'b0;
            core_load  = 1'b0;
            core_step  = 1'b0;
            core_zload = 1'b0;
            core_clear = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            signed_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            div0_q   <= 1'b0;
            early_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            if (capture) begin
                signed_q <= signed_i;
                sa_q     <= opa_i[31];
                sb_q     <= opb_i[31];
                div0_q   <= (opb_i == '0);
                early_q  <= early_hit;
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
// Self-checking bench for div_ctrl: directed vector table, randomized
// divisions against an arithmetic reference, and hand-written sequences for
// annul, flush-in-DONE, held start and mid-division reset.
// -----------------------------------------------------------------------------
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic        annul_i;
    logic        stall_o;
    logic        ready_o;
    logic [63:0] result_o;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [63:0] last_res = '0;

`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    typedef struct {
        bit          sg;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [63:0] res;
    } vec_t;

    vec_t vecs[10];

    div_ctrl #(
        .DIV_ITERS (32)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (start_i),
        .signed_i (signed_i),
        .opa_i    (opa_i),
        .opb_i    (opb_i),
        .annul_i  (annul_i),
        .stall_o  (stall_o),
        .ready_o  (ready_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with C-style truncation.
    function automatic void ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                    output logic [63:0] res, output int lat);
        longint sa, sb, q, r;
        if (b == 32'h0) begin
            res = {a, 32'hFFFF_FFFF};
            lat = 2;
            return;
        end
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q   = sa / sb;
        r   = sa % sb;
        res = {r[31:0], q[31:0]};
        lat = 33;
        if (((sa < 0) ? -sa : sa) < ((sb < 0) ? -sb : sb)) lat = EARLY_LAT;
    endfunction

    // Entered and left just after a rising edge with the DUT idle.
    task automatic run_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                           input int exp_lat, input logic [63:0] exp_res,
                           input bit hold, input string tag);
        int lat;
        bit stall_ok;
        lat      = -1;
        stall_ok = 1'b1;
        start_i  = 1'b1;
        signed_i = sg;
        opa_i    = a;
        opb_i    = b;
        @(negedge clk);
        chk({tag, " stall@0"}, 64'(stall_o), 64'd1);
        @(posedge clk); #1;
        // Scramble operands so any resampling corrupts the result.
        start_i  = hold;
        signed_i = 1'($urandom_range(0, 1));
        opa_i    = $urandom;
        opb_i    = $urandom;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (ready_o) begin
                lat = c;
                chk({tag, " result"}, result_o, exp_res);
                chk({tag, " stall@ready"}, 64'(stall_o), 64'd0);
                start_i = 1'b0;
            end else if (!stall_o) begin
                stall_ok = 1'b0;
            end
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " stall continuous"}, 64'(stall_ok), 64'd1);
        @(negedge clk);
        chk({tag, " ready width"}, 64'(ready_o), 64'd0);
        chk({tag, " result hold"}, result_o, exp_res);
        @(posedge clk); #1;
        last_res = exp_res;
    endtask

    initial begin
        logic [63:0] r_res;
        int          r_lat;
        logic [31:0] ra, rb;
        bit          rsg;
        int          ready_cnt;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        33,        {32'd2, 32'd14}};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        33,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
        vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 33,       {32'h0, 32'h8000_0000}};
        vecs[3] = '{1'b0, 32'd5,          32'd0,        2,         {32'd5, 32'hFFFF_FFFF}};
        vecs[4] = '{1'b0, 32'd3,          32'd5,        EARLY_LAT, {32'd3, 32'd0}};
        vecs[5] = '{1'b1, 32'hFFFF_FFFB,  32'd0,        2,         {32'hFFFF_FFFB, 32'hFFFF_FFFF}};
        vecs[6] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 33,       {32'd1, 32'hFFFF_FFFD}};
        vecs[7] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        33,        {32'd0, 32'hFFFF_FFFF}};
        vecs[8] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 33,       {32'd0, 32'd1}};
        vecs[9] = '{1'b1, 32'hFFFF_FFFF,  32'd7,        EARLY_LAT, {32'hFFFF_FFFF, 32'd0}};

        resetn   = 1'b0;
        start_i  = 1'b0;
        signed_i = 1'b0;
        opa_i    = '0;
        opb_i    = '0;
        annul_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset stall", 64'(stall_o), 64'd0);
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset result", result_o, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_div(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].res,
                    1'b0, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 25; i++) begin
            rsg = 1'($urandom_range(0, 1));
            ra  = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'h0;
                1, 2:    rb = $urandom_range(1, 15);
                3:       rb = 32'hFFFF_FFFF;
                4:       rb = ra + 32'd1;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            ref_div(rsg, ra, rb, r_res, r_lat);
            run_div(rsg, ra, rb, r_lat, r_res, 1'b0, $sformatf("rand%0d", i));
        end

        // start held high for the whole division must be ignored.
        run_div(1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, 1'b1, "held start");

        // Annul at cycle 10, fresh start at cycle 12.
        run_div(1'b0, 32'd1000, 32'd3, 33, {32'd1, 32'd333}, 1'b0, "pre annul");
        start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd100; opb_i = 32'd9;
        @(negedge clk);
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(negedge clk);
        chk("annul stall", 64'(stall_o), 64'd0);
        chk("annul ready", 64'(ready_o), 64'd0);
        @(posedge clk); #1;
        annul_i = 1'b0;
        @(negedge clk);
        chk("post annul stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        run_div(1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, 1'b0, "after annul");

        // Annul landing on the DONE cycle suppresses ready and keeps old result.
        start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd50; opb_i = 32'd8;
        @(negedge clk);
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(negedge clk);
        chk("annul done ready", 64'(ready_o), 64'd0);
        chk("annul done stall", 64'(stall_o), 64'd0);
        chk("annul done result", result_o, last_res);
        @(posedge clk); #1;
        annul_i = 1'b0;
        @(negedge clk);
        chk("annul done after ready", 64'(ready_o), 64'd0);
        chk("annul done after result", result_o, last_res);
        @(posedge clk); #1;

        // Reset at cycle 20 of a division.
        start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd100; opb_i = 32'd7;
        @(negedge clk);
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midreset stall", 64'(stall_o), 64'd0);
        chk("midreset ready", 64'(ready_o), 64'd0);
        chk("midreset result", result_o, 64'd0);
        @(posedge clk); #1;
        resetn    = 1'b1;
        ready_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready_o) ready_cnt++;
            @(posedge clk); #1;
        end
        chk("midreset no ready", 64'(ready_cnt), 64'd0);
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 33, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0, "after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter DIV_ITERS, default 32: number of radix-2 iteration cycles per division.
REQ-002 clk  input  1  rising-edge clock; the block has one clock.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 start_i  input  1  DIV/DIVU instruction present in the execute stage with operands valid.
REQ-005 signed_i  input  1  1 = DIV (signed), 0 = DIVU; sampled with start_i.
REQ-006 opa_i  input  32  dividend; sampled with start_i.
REQ-007 opb_i  input  32  divisor; sampled with start_i.
REQ-008 annul_i  input  1  exception flush; kills any in-flight division.
REQ-009 stall_o  output  1  pipeline stall request, fed to the hazard unit as div_start.
REQ-010 ready_o  output  1  one-cycle pulse; result_o is valid for this cycle only.
REQ-011 result_o  output  64  {hi = remainder, lo = quotient}.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, BUSY, ZERO, DONE.
REQ-013 In IDLE with start_i=1 and annul_i=0, the block SHALL latch signed_i, the operand magnitudes (absolute values when signed) and both sign bits, and SHALL move to ZERO if opb_i==0, else to BUSY.
REQ-014 In BUSY, the block SHALL perform one restoring shift-subtract step per cycle for DIV_ITERS cycles, then move to DONE.
REQ-015 In ZERO, the block SHALL load hi=opa_i and lo=32'hFFFFFFFF and move to DONE after one cycle.
REQ-016 In DONE, the block SHALL assert ready_o=1 and stall_o=0, drive result_o, and return to IDLE the next cycle.
REQ-017 stall_o SHALL equal (state==IDLE & start_i & ~annul_i) | state==BUSY | state==ZERO.
REQ-018 Latency for a nonzero divisor: start accepted at cycle 0; BUSY during cycles 1..32; ready_o at cycle 33; stall_o high for cycles 0..32.
REQ-019 Sign correction SHALL be applied in DONE: quotient negated iff signed and the operand signs differ; remainder takes the dividend's sign.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 (wrap, no trap).
REQ-021 start_i outside IDLE SHALL be ignored; operands SHALL NOT be resampled while busy.
REQ-022 annul_i=1 in any state SHALL force IDLE at the next edge, suppress ready_o (including in DONE) and drop stall_o the same cycle.
REQ-023 result_o SHALL hold its last DONE value at all other times; it is 0 after reset.

Reset
REQ-024 resetn=0 at a clock edge SHALL force state=IDLE, stall_o=0, ready_o=0, result_o=0 and all iteration registers to 0, including mid-division.
REQ-025 A division interrupted by reset SHALL NOT produce ready_o.

Configuration
REQ-026 Macro DIV_EARLY_OUT_EN: when defined and |dividend| < |divisor| (divisor nonzero), the block SHALL skip BUSY, go IDLE->DONE, and return lo=0 with hi = the signed dividend (ready_o at cycle 1).
REQ-027 Without DIV_EARLY_OUT_EN, every nonzero-divisor division SHALL take the full REQ-018 latency.

Structure
REQ-028 The FSM state encoding and the DIV_ITERS default SHALL live in shared package cpu_defs_pkg.
REQ-029 The shift/subtract datapath (partial remainder, quotient register, iteration counter) SHALL be sub-module div_core; div_ctrl owns the FSM, sign handling and stall/ready.

Verification
REQ-030 DIVU 100/7: start at cycle 0 -> stall_o high cycles 0..32, ready_o at 33, lo=14, hi=2.
REQ-031 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 DIVU 5/0 -> ready_o at cycle 2, hi=5, lo=0xFFFFFFFF.
REQ-033 annul_i pulsed at cycle 10 of a division -> stall_o=0 at cycle 10, no ready_o, and a new start at cycle 12 completes normally.
REQ-034 resetn low at cycle 20 -> all outputs 0 next cycle, no ready_o; a start held high during BUSY is ignored.
REQ-035 With DIV_EARLY_OUT_EN defined, DIVU 3/5 -> ready_o at cycle 1, lo=0, hi=3; without the macro, ready_o at cycle 33.
